// File: rtl/multibyte_add_ctrl.sv
// Byte-serial sequencer that drives a shared 8-bit adder for NBYTES cycles,
// chaining carry internally, to produce a full-width add or subtract.
`timescale 1ns/1ps
module multibyte_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic                  Sub,
  input  logic [8*NBYTES-1:0]   Op_A,
  input  logic [8*NBYTES-1:0]   Op_B,
  output logic                  Busy,
  output logic                  Done,
  output logic [8*NBYTES-1:0]   Result,
  output logic                  Cout,
  output logic                  Ovr,
  output logic [7:0]            Add_A,
  output logic [7:0]            Add_B,
  output logic                  Add_Cin,
  input  logic [7:0]            Add_Sum,
  input  logic                  Add_Cout,
  input  logic                  Add_Ovr
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SEL_W = IDX_W + 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       a_reg, b_reg, work, final_word;
  logic               sub_reg, carry_reg;
  logic [IDX_W-1:0]   idx;
  logic [SEL_W-1:0]   sel;
  logic               last_byte, accept;

  assign sel       = {idx, 3'b000};
  assign last_byte = (idx == IDX_W'(NBYTES - 1));
  assign accept    = Start && (state == IDLE || state == DONE);

  // Final result is the already-collected lower bytes with the MSB byte
  // taken straight from the adder on the last RUN edge.
  always_comb begin
    final_word           = work;
    final_word[W-1 -: 8] = Add_Sum;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
      work      <= '0;
      Result    <= '0;
      Cout      <= 1'b0;
      Ovr       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg     <= Op_A;
        b_reg     <= Op_B;
        sub_reg   <= Sub;
        carry_reg <= Sub;
        idx       <= '0;
      end else if (state == RUN) begin
        work[sel +: 8] <= Add_Sum;
        carry_reg      <= Add_Cout;
        if (last_byte) begin
          Result <= final_word;
          Cout   <= Add_Cout;
          Ovr    <= Add_Ovr;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    Add_A     = '0;
    Add_B     = '0;
    Add_Cin   = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_nxt = RUN;
      end
      RUN: begin
        Busy    = 1'b1;
        Add_A   = a_reg[sel +: 8];
        Add_B   = b_reg[sel +: 8] ^ {8{sub_reg}};
        Add_Cin = carry_reg;
        if (last_byte) state_nxt = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = Start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
